// File: rtl/sort_topk_collect_pkg.sv
// Shared definitions for the sort top-K collector: FSM encoding and the
// default data/index widths also used by the input address generator.
package sort_topk_collect_pkg;

    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_IW = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_FINISH  = 2'd3;

    // Pointer width for a K-entry table; never narrower than one bit.
    function automatic int unsigned ptr_width(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/topk_insert_slot.sv
// One entry of the descending top-K table: compares the incoming sample,
// then holds, takes the sample, or takes the entry shifted down from above.
module topk_insert_slot
    import sort_topk_collect_pkg::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned IW = DEF_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          smp_en,
    input  logic [DW-1:0] smp_val,
    input  logic [IW-1:0] smp_idx,
    input  logic          up_gt,
    input  logic          up_vld,
    input  logic [DW-1:0] up_val,
    input  logic [IW-1:0] up_idx,
    output logic          gt_c,
    output logic          vld_c,
    output logic [DW-1:0] val_c,
    output logic [IW-1:0] idx_c,
    output logic          o_vld,
    output logic [DW-1:0] o_val,
    output logic [IW-1:0] o_idx
);

    logic          vld_q, vld_d;
    logic [DW-1:0] val_q, val_d;
    logic [IW-1:0] idx_q, idx_d;

    // Strictly-less compare keeps equal values in arrival order.
    always_comb begin
        gt_c  = !vld_q || ($signed(val_q) < $signed(smp_val));
        vld_d = vld_q;
        val_d = val_q;
        idx_d = idx_q;
        if (clr) begin
            vld_d = 1'b0;
            val_d = '0;
            idx_d = '0;
        end else if (smp_en && gt_c) begin
            if (up_gt) begin
                vld_d = up_vld;
                val_d = up_val;
                idx_d = up_idx;
            end else begin
                vld_d = 1'b1;
                val_d = smp_val;
                idx_d = smp_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            val_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q <= vld_d;
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign vld_c = vld_d;
    assign val_c = val_d;
    assign idx_c = idx_d;
    assign o_vld = vld_q;
    assign o_val = val_q;
    assign o_idx = idx_q;

endmodule

// File: rtl/sort_topk_collect.sv
// Collects IO-buffer read data behind the IAGU, keeps a stable descending
// top-K list of (value, index), then drains it over a valid/ready port.
module sort_topk_collect
    import sort_topk_collect_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned K      = 4,
    parameter int unsigned IW     = DEF_IW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_calculate,
    input  logic [IW-1:0] in_piece,
    input  logic          i_rd_en,
    input  logic [DW-1:0] i_d_data,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_value,
    output logic [IW-1:0] o_index,
    output logic          o_last,
    output logic          o_busy,
    output logic          o_done
);

    localparam int unsigned PW = ptr_width(K);
    localparam int unsigned CW = ((IW > PW) ? IW : PW) + 1;

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     piece_q, piece_d;
    logic [IW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [RD_LAT-1:0] rd_sr_q, rd_sr_d;

    logic          o_valid_q, o_valid_d;
    logic [DW-1:0] o_value_q, o_value_d;
    logic [IW-1:0] o_index_q, o_index_d;
    logic          o_last_q, o_last_d;
    logic          o_busy_q, o_busy_d;
    logic          o_done_q, o_done_d;

    logic          smp_en_c;
    logic [CW-1:0] nbeats_c;
    logic [CW-1:0] last_ptr_c;

    logic [K-1:0]  slot_gt_c;
    logic [K-1:0]  slot_vld_c;
    logic [DW-1:0] slot_val_c [K];
    logic [IW-1:0] slot_idx_c [K];
    logic [K-1:0]  slot_vld_q;
    logic [DW-1:0] slot_val_q [K];
    logic [IW-1:0] slot_idx_q [K];

    // Read-strobe delay line; nothing enters it while idle, and a start flushes it.
    always_comb begin
        rd_sr_d    = '0;
        rd_sr_d[0] = (state_q != ST_IDLE) && i_rd_en;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_sr_d[i] = rd_sr_q[i-1];
        end
        if (start_calculate) begin
            rd_sr_d = '0;
        end
    end

    assign smp_en_c = (state_q == ST_COLLECT) && rd_sr_q[RD_LAT-1] &&
                      (cnt_q != piece_q) && !start_calculate;

    for (genvar g = 0; g < K; g++) begin : g_slot
        logic          up_gt;
        logic          up_vld;
        logic [DW-1:0] up_val;
        logic [IW-1:0] up_idx;

        if (g == 0) begin : g_head
            assign up_gt  = 1'b0;
            assign up_vld = 1'b0;
            assign up_val = '0;
            assign up_idx = '0;
        end else begin : g_body
            assign up_gt  = slot_gt_c[g-1];
            assign up_vld = slot_vld_q[g-1];
            assign up_val = slot_val_q[g-1];
            assign up_idx = slot_idx_q[g-1];
        end

        topk_insert_slot #(
            .DW (DW),
            .IW (IW)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .clr     (start_calculate),
            .smp_en  (smp_en_c),
            .smp_val (i_d_data),
            .smp_idx (cnt_q),
            .up_gt   (up_gt),
            .up_vld  (up_vld),
            .up_val  (up_val),
            .up_idx  (up_idx),
            .gt_c    (slot_gt_c[g]),
            .vld_c   (slot_vld_c[g]),
            .val_c   (slot_val_c[g]),
            .idx_c   (slot_idx_c[g]),
            .o_vld   (slot_vld_q[g]),
            .o_val   (slot_val_q[g]),
            .o_idx   (slot_idx_q[g])
        );
    end

    // The tail entry's compare and contents have no slot below to shift into.
    logic unused_tail;
    assign unused_tail = ^{slot_gt_c[K-1], slot_vld_q[K-1], slot_val_q[K-1], slot_idx_q[K-1]};

    assign nbeats_c   = (CW'(piece_q) < CW'(K)) ? CW'(piece_q) : CW'(K);
    assign last_ptr_c = nbeats_c - CW'(1);

    // Next-state logic; a start in any state (re)launches a job.
    always_comb begin
        state_d = state_q;
        piece_d = piece_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_COLLECT: begin
                if (piece_q == '0) begin
                    state_d = ST_FINISH;
                end else if (smp_en_c) begin
                    cnt_d = IW'(cnt_q + IW'(1));
                    if (IW'(cnt_q + IW'(1)) == piece_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (o_valid_q && i_ready) begin
                    if (o_last_q) begin
                        state_d = ST_FINISH;
                    end else begin
                        ptr_d = PW'(ptr_q + PW'(1));
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_calculate) begin
            state_d = ST_COLLECT;
            piece_d = in_piece;
            cnt_d   = '0;
            ptr_d   = '0;
        end
    end

    // Outputs are registered from next-state values so the first beat lands
    // the cycle after the final sample is captured.
    always_comb begin
        o_valid_d = 1'b0;
        o_value_d = '0;
        o_index_d = '0;
        o_last_d  = 1'b0;
        o_busy_d  = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
        o_done_d  = (state_d == ST_FINISH);
        if ((state_d == ST_DRAIN) && slot_vld_c[ptr_d]) begin
            o_valid_d = 1'b1;
            o_value_d = slot_val_c[ptr_d];
            o_index_d = slot_idx_c[ptr_d];
            o_last_d  = (CW'(ptr_d) == last_ptr_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            piece_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            rd_sr_q   <= '0;
            o_valid_q <= 1'b0;
            o_value_q <= '0;
            o_index_q <= '0;
            o_last_q  <= 1'b0;
            o_busy_q  <= 1'b0;
            o_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            piece_q   <= piece_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rd_sr_q   <= rd_sr_d;
            o_valid_q <= o_valid_d;
            o_value_q <= o_value_d;
            o_index_q <= o_index_d;
            o_last_q  <= o_last_d;
            o_busy_q  <= o_busy_d;
            o_done_q  <= o_done_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_value = o_value_q;
    assign o_index = o_index_q;
    assign o_last  = o_last_q;
    assign o_busy  = o_busy_q;
    assign o_done  = o_done_q;

endmodule
